// File: rtl/fp_compare_pipe.sv
// ============================================================================
// fp_compare_pipe : two-stage elastic three-way sign-magnitude comparator
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fp_compare_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abs_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         gt,
  output logic         eq,
  output logic         lt,
  output logic [15:0]  cmp_count
);

  localparam int M_W = EXP_W + MAN_W;

  logic [M_W-1:0] mag_a, mag_b;
  assign mag_a = a[M_W-1:0];
  assign mag_b = b[M_W-1:0];

  logic s2_free, s1_load, s1_adv;

  logic s1_valid_q, s1_valid_d;
  logic s1_sign_a_q, s1_sign_a_d;
  logic s1_sign_b_q, s1_sign_b_d;
  logic s1_zero_a_q, s1_zero_a_d;
  logic s1_zero_b_q, s1_zero_b_d;
  logic s1_mag_gt_q, s1_mag_gt_d;
  logic s1_mag_eq_q, s1_mag_eq_d;
  logic s1_abs_q,    s1_abs_d;

  logic        out_valid_q, out_valid_d;
  logic        gt_q, gt_d;
  logic        eq_q, eq_d;
  logic        lt_q, lt_d;
  logic [15:0] cmp_count_q, cmp_count_d;

  logic res_gt, res_eq, res_lt, mag_lt;

  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_free;
    s1_load  = in_valid && in_ready;
    s1_adv   = s1_valid_q && s2_free;
  end

  // Stage 1: magnitude compare on the raw operands, sign info kept for stage 2
  always_comb begin
    s1_valid_d  = s1_load || (s1_valid_q && !s1_adv);
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    s1_zero_a_d = s1_zero_a_q;
    s1_zero_b_d = s1_zero_b_q;
    s1_mag_gt_d = s1_mag_gt_q;
    s1_mag_eq_d = s1_mag_eq_q;
    s1_abs_d    = s1_abs_q;
    if (s1_load) begin
      s1_sign_a_d = a[W-1];
      s1_sign_b_d = b[W-1];
      s1_zero_a_d = (mag_a == '0);
      s1_zero_b_d = (mag_b == '0);
      s1_mag_gt_d = (mag_a > mag_b);
      s1_mag_eq_d = (mag_a == mag_b);
      s1_abs_d    = abs_mode;
    end
  end

  always_comb begin
    res_gt = 1'b0;
    res_eq = 1'b0;
    res_lt = 1'b0;
    mag_lt = !s1_mag_gt_q && !s1_mag_eq_q;
    if (s1_abs_q) begin
      res_gt = s1_mag_gt_q;
      res_eq = s1_mag_eq_q;
      res_lt = mag_lt;
    end else if (s1_zero_a_q && s1_zero_b_q) begin
      res_eq = 1'b1;
    end else if (s1_sign_a_q != s1_sign_b_q) begin
      // a signed zero only reaches here against a non-zero, so sign alone decides
      res_gt = !s1_sign_a_q;
      res_lt = s1_sign_a_q;
    end else if (!s1_sign_a_q) begin
      res_gt = s1_mag_gt_q;
      res_eq = s1_mag_eq_q;
      res_lt = mag_lt;
    end else begin
      res_gt = mag_lt;
      res_eq = s1_mag_eq_q;
      res_lt = s1_mag_gt_q;
    end
  end

  // Stage 2: results are forced low whenever the slot empties
  always_comb begin
    out_valid_d = out_valid_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    cmp_count_d = cmp_count_q;
    if (s2_free) begin
      out_valid_d = s1_valid_q;
      gt_d        = s1_valid_q && res_gt;
      eq_d        = s1_valid_q && res_eq;
      lt_d        = s1_valid_q && res_lt;
    end
    if (out_valid_q && out_ready) begin
      cmp_count_d = cmp_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_a_q <= 1'b0;
      s1_sign_b_q <= 1'b0;
      s1_zero_a_q <= 1'b0;
      s1_zero_b_q <= 1'b0;
      s1_mag_gt_q <= 1'b0;
      s1_mag_eq_q <= 1'b0;
      s1_abs_q    <= 1'b0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      cmp_count_q <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_a_q <= s1_sign_a_d;
      s1_sign_b_q <= s1_sign_b_d;
      s1_zero_a_q <= s1_zero_a_d;
      s1_zero_b_q <= s1_zero_b_d;
      s1_mag_gt_q <= s1_mag_gt_d;
      s1_mag_eq_q <= s1_mag_eq_d;
      s1_abs_q    <= s1_abs_d;
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      cmp_count_q <= cmp_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign cmp_count = cmp_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
// ============================================================================
// tb_fp_compare_pipe : directed bench for fp_compare_pipe (13-bit and 32-bit)
// Revision           : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fp_compare_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, abs_mode, out_valid, out_ready, gt, eq, lt;
  logic [12:0] a, b;
  logic [15:0] cmp_count;

  logic        in_valid32, in_ready32, abs32, out_valid32, out_ready32, gt32, eq32, lt32;
  logic [31:0] a32, b32;
  logic [15:0] cmp_count32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_compare_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .abs_mode(abs_mode), .out_valid(out_valid),
    .out_ready(out_ready), .gt(gt), .eq(eq), .lt(lt), .cmp_count(cmp_count)
  );

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .abs_mode(abs32), .out_valid(out_valid32),
    .out_ready(out_ready32), .gt(gt32), .eq(eq32), .lt(lt32), .cmp_count(cmp_count32)
  );

  // Ordering key: a signed integer, so -0 and +0 collapse to the same value
  function automatic logic [2:0] ref_cmp(input logic [12:0] x, input logic [12:0] y,
                                         input logic absm);
    int kx, ky;
    kx = int'(x[11:0]);
    ky = int'(y[11:0]);
    if (!absm) begin
      if (x[12]) kx = -kx;
      if (y[12]) ky = -ky;
    end
    return {kx > ky, kx == ky, kx < ky};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [12:0] ta, input logic [12:0] tb,
                      input logic tabs, input logic [2:0] exp);
    @(negedge clk);
    a = ta; b = tb; abs_mode = tabs; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'({gt, eq, lt}), 32'(exp));
  endtask

  task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [2:0] exp);
    @(negedge clk);
    a32 = ta; b32 = tb; in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid32), 32'd1);
    chk(tag, 32'({gt32, eq32, lt32}), 32'(exp));
  endtask

  logic [12:0] bp_a   [4] = '{13'h0100, 13'h0010, 13'h1234, 13'h1002};
  logic [12:0] bp_b   [4] = '{13'h0080, 13'h0020, 13'h1234, 13'h1001};
  logic [2:0]  bp_exp [4] = '{3'b100,   3'b001,   3'b010,   3'b001};
  logic [2:0]  got    [8];
  logic [2:0]  exp_q  [$];
  logic [2:0]  e;
  int          idx, nres;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; abs_mode = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; abs32 = 1'b0; out_ready32 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({gt, eq, lt}), 32'd0);
    chk("rst_count", 32'(cmp_count), 32'd0);
    rst_n = 1'b1;

    // Backpressure: four pairs offered back to back, sink stalled for 5 cycles
    idx = 0; nres = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      out_ready = (k >= 5);
      if (idx < 4) begin
        in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx]; abs_mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 2) begin
        chk("bp_accepts_before_stall", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      if (k >= 2 && k <= 4) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_first", 32'({gt, eq, lt}), 32'b100);
      end
      if (out_valid && out_ready) begin
        if (nres < 8) got[nres] = {gt, eq, lt};
        nres++;
      end
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    chk("bp_result_count", 32'(nres), 32'd4);
    for (int r = 0; r < 4; r++) chk($sformatf("bp_result_%0d", r), 32'(got[r]), 32'(bp_exp[r]));
    chk("bp_cmp_count", 32'(cmp_count), 32'd4);

    // Zeros and magnitude-only mode
    run1("zero_pos_neg_eq", 13'h0000, 13'h1000, 1'b0, 3'b010);
    run1("pos_zero_gt_neg", 13'h0000, 13'h1001, 1'b0, 3'b100);
    run1("neg_zero_lt_pos", 13'h1000, 13'h0001, 1'b0, 3'b001);
    run1("abs_big_gt", 13'h1FFF, 13'h0001, 1'b1, 3'b100);
    run1("abs_sign_eq", 13'h1005, 13'h0005, 1'b1, 3'b010);
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_flags", 32'({gt, eq, lt}), 32'd0);

    // Exhaustive sweep of a against a fixed negative b
    b = 13'h14CA; abs_mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8194; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        chk("sweep_valid", 32'(out_valid), 32'd1);
        chk("sweep_model", 32'({gt, eq, lt}), 32'(e));
        if (i - 2 == 32'h0001) chk("sweep_a1_gt", 32'({gt, eq, lt}), 32'b100);
        if (i - 2 == 32'h14CA) chk("sweep_aeqb", 32'({gt, eq, lt}), 32'b010);
        if (i - 2 == 32'h1500) chk("sweep_neg_lt", 32'({gt, eq, lt}), 32'b001);
      end
      if (i < 8192) begin
        a = 13'(i); in_valid = 1'b1;
        exp_q.push_back(ref_cmp(13'(i), 13'h14CA, 1'b0));
      end else begin
        in_valid = 1'b0;
      end
    end

    // Reset between edges with both stages occupied
    out_ready = 1'b0;
    @(negedge clk); a = 13'h0100; b = 13'h0080; in_valid = 1'b1;
    @(negedge clk); a = 13'h0010; b = 13'h0020;
    @(negedge clk); in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_flags", 32'({gt, eq, lt}), 32'd0);
    chk("mid_rst_count", 32'(cmp_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_count", 32'(cmp_count), 32'd0);
    run1("post_rst_pair", 13'h0005, 13'h0003, 1'b0, 3'b100);

    // Single-precision layout
    run32("sp_pos1_gt_neg1", 32'h3F800000, 32'hBF800000, 3'b100);
    run32("sp_neg1_lt_pos1", 32'hBF800000, 32'h3F800000, 3'b001);
    run32("sp_neg2_lt_neg1", 32'hC0000000, 32'hBF800000, 3'b001);
    run32("sp_one_eq_one", 32'h3F800000, 32'h3F800000, 3'b010);

    // Counter wrap: 1 result so far plus 65536 more gives 65537 in total
    @(negedge clk);
    chk("wrap_start", 32'(cmp_count), 32'd1);
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (i == 1000) chk("wrap_mid", 32'(cmp_count), 32'd999);
      a = 13'(i); b = 13'h0800; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_end", 32'(cmp_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Pipelined, parametrised comparator for sign-magnitude floating-point words laid out as {sign, exponent[EXP_W-1:0], mantissa[MAN_W-1:0]}.
- Generalises the fixed 13-bit (1/4/8) greater-than comparator in three ways: configurable field widths, full three-way result (gt/eq/lt), and a per-transaction magnitude-only mode.
- Sits between operand producers and sort/select logic behind a two-stage valid/ready elastic pipeline with full backpressure.

Parameters:
- EXP_W, 4, exponent field width (>=1).
- MAN_W, 8, mantissa field width (>=1).
- W, 1+EXP_W+MAN_W, derived operand width; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage 1 can accept this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- abs_mode  in  1  1 = compare magnitudes only, signs ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- gt  out  1  A > B.
- eq  out  1  A == B.
- lt  out  1  A < B.
- cmp_count  out  16  number of results accepted downstream, wrapping.

Behaviour:
- Reset (asynchronous, rst_n low): out_valid=0, gt=0, eq=0, lt=0, cmp_count=0, internal stage-1 valid=0.
  - in_ready is 1 whenever stage 1 is empty, so it reads 1 during and after reset.
  - Reset mid-transaction discards all in-flight data; no partial result appears after release.
- Magnitude:
  - mag = {exp, man}, compared as an unsigned (EXP_W+MAN_W)-bit value.
  - zero = (mag == 0). The sign of a zero is ignored, so +0 == -0.
- Compare rules, in priority order:
  1. abs_mode=1: gt = magA>magB; eq = magA==magB; lt = magA<magB.
  2. Both operands zero: eq=1.
  3. Signs differ: the positive operand is greater; a non-zero negative is always less than any zero.
  4. Both positive: order by magnitude.
  5. Both negative: order reversed (larger magnitude is smaller).
- Exactly one of gt/eq/lt is 1 whenever out_valid=1. All three are 0 when out_valid=0.
- Stage 1 (registered):
  - Captures sign bits, zero flags, magnitude-greater, magnitude-equal and abs_mode when in_valid && in_ready.
  - Magnitude compare runs on the register inputs.
- Stage 2 (registered): resolves the sign rules into gt/eq/lt and sets out_valid.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational).
  - Simultaneous accept-in and advance in the same cycle must be supported, giving throughput of one result per cycle when out_ready=1.
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, with no stall.
- Backpressure:
  - While out_valid && !out_ready, gt/eq/lt hold stable.
  - Stage 1 holds its data; in_ready falls once stage 1 is also full.
  - Inputs a, b and abs_mode are don't-care when not accepted.
- Ordering: results leave in acceptance order. No data is dropped or duplicated.
- cmp_count: increments on each out_valid && out_ready and wraps 0xFFFF -> 0x0000.

Test Plan:
- Default widths, b=13'b1_0100_11001010, abs_mode=0; sweep all 8192 values of a at out_ready=1.
  - Each result must match the reference model, and a new result must appear every cycle after the 2-cycle fill.
  - Check: a=13'b0_0000_00000001 -> gt.
  - Check: a=b -> eq.
  - Check: a=13'b1_0101_00000000 -> lt.
- Zeros:
  - a=13'b0_0000_00000000, b=13'b1_0000_00000000 -> eq.
  - a=+0, b=13'b1_0000_00000001 -> gt.
  - abs_mode=1 with a=13'b1_1111_11111111, b=13'b0_0000_00000001 -> gt.
- Backpressure: issue 4 back-to-back pairs with out_ready held low for 5 cycles.
  - in_ready deasserts after 2 accepts.
  - out_valid stays asserted with the first result stable.
  - After out_ready is released, all 4 results emerge in order with no loss or duplicate, and cmp_count=4.
- Reset mid-flight: assert rst_n=0 asynchronously between clock edges with both stages full.
  - Outputs clear immediately.
  - After release, in_ready=1, out_valid stays 0 until a new pair is accepted, and cmp_count=0.
- Parametrisation: EXP_W=8, MAN_W=23.
  - a=32'h3F800000 (1.0), b=32'hBF800000 (-1.0) -> gt.
  - Swapped operands -> lt.
  - a=32'hC0000000 (-2.0) vs b=-1.0 -> lt.
- Counter wrap: force 65537 accepted results -> cmp_count=1.
